// File: rtl/biu_master.sv
// Single-outstanding bus interface master: arbitrates for a shared tri-state bus,
// drives a one-cycle request, then waits for a write-capture cycle or a read response.
module biu_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rnw,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  inout  wire  [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    ARB      = 5'b00010,
    SEND_REQ = 5'b00100,
    WAIT_RSP = 5'b01000,
    DONE     = 5'b10000
  } state_t;

  state_t                  state_r, state_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic                    rnw_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    ready_r, done_r, error_r, bus_req_r, drive_r;
  logic [DATA_WIDTH-1:0]   data_out_r;
  logic                    accept_s, capture_s, err_s, rsp_s;

  // Busy (2'b10), floating or unknown control lines never qualify as a response.
  assign rsp_s = (bus_control == 2'b11);

  // Next-state, timeout counter and per-cycle strobes.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && ready_r) begin
          accept_s = 1'b1;
          state_s  = ARB;
        end else begin
          state_s  = IDLE;
        end
      end
      ARB: begin
        if (bus_gnt) begin
          state_s = SEND_REQ;
        end else begin
          state_s = ARB;
        end
      end
      SEND_REQ: begin
        state_s = WAIT_RSP;
        cnt_s   = '0;
      end
      WAIT_RSP: begin
        if (!rnw_r) begin
          state_s = DONE;
        end else if (rsp_s) begin
          capture_s = 1'b1;
          state_s   = DONE;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request latch, result registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      rnw_r      <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      bus_req_r  <= 1'b0;
      drive_r    <= 1'b0;
      data_out_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        rnw_r   <= rnw;
        addr_r  <= address;
        wdata_r <= data_in;
      end
      if (capture_s) begin
        data_out_r <= bus_data;
      end
      if ((state_r == WAIT_RSP) && (state_s == DONE)) begin
        error_r <= err_s;
      end
      // ready trails the return to IDLE by one cycle and drops as soon as en is taken.
      ready_r   <= (state_r == IDLE) && !accept_s;
      done_r    <= (state_s == DONE);
      bus_req_r <= (state_s == ARB) || (state_s == SEND_REQ) || (state_s == WAIT_RSP);
      drive_r   <= (state_s == SEND_REQ);
    end
  end

  assign ready    = ready_r;
  assign done     = done_r;
  assign error    = error_r;
  assign data_out = data_out_r;
  assign bus_req  = bus_req_r;

  assign bus_address = drive_r ? addr_r           : {ADDR_WIDTH{1'bz}};
  assign bus_data    = drive_r ? wdata_r          : {DATA_WIDTH{1'bz}};
  assign bus_control = drive_r ? {rnw_r, 1'b1}    : 2'bzz;

endmodule

// File: tb/tb_biu_master.sv
// Bench for biu_master: vector table of transactions against a behavioural slave,
// scoreboard on every done pulse, plus hand sequences for reset and held-en cases.
module tb_biu_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [AW-1:0] SLAVE_ADDR = 32'h0000_0010;

  logic          clk = 1'b0;
  logic          rst, en, rnw, bus_gnt;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          ready, done, error, bus_req;
  logic [DW-1:0] data_out;
  wire  [AW-1:0] bus_address;
  wire  [DW-1:0] bus_data;
  wire  [1:0]    bus_control;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            gnt_dly;
    int            busy;
  } txn_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  txn_t          vec[10];
  logic [DW-1:0] last_rd;

  logic          s_act  = 1'b0;
  int            s_left = 0;
  int            s_busy;
  logic [DW-1:0] s_data;

  always #5 clk = ~clk;

  biu_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .rnw(rnw), .address(address), .data_in(data_in),
    .ready(ready), .done(done), .error(error), .data_out(data_out),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_address(bus_address), .bus_data(bus_data), .bus_control(bus_control)
  );

  // Slave mapped at SLAVE_ADDR: answers reads after s_busy busy cycles.
  always @(posedge clk) begin
    if (rst) begin
      s_act  <= 1'b0;
      s_left <= 0;
    end else if (s_act) begin
      if (s_left == 0) s_act <= 1'b0;
      else s_left <= s_left - 1;
    end else if (bus_control === 2'b11 && bus_address === SLAVE_ADDR) begin
      s_act  <= 1'b1;
      s_left <= s_busy;
    end
  end

  assign bus_control = s_act ? ((s_left == 0) ? 2'b11 : 2'b10) : 2'bzz;
  assign bus_data    = s_act ? s_data : {DW{1'bz}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic bus_idle();
    logic a, d, c;
    a = (bus_address === {AW{1'bz}}) || (bus_address === {AW{1'b0}});
    d = (bus_data    === {DW{1'bz}}) || (bus_data    === {DW{1'b0}});
    c = (bus_control === 2'bzz)      || (bus_control === 2'b00);
    return a && d && c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done=1 required no pending transaction");
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_error", 64'(error), 64'(mon_e.err));
        chk("sb_data_out", 64'(data_out), 64'(mon_e.data));
      end
    end
  end

  task automatic wait_ready();
    for (int n = 0; n < 40 && ready !== 1'b1; n++) tick();
    chk("ready_before_txn", 64'(ready), 64'd1);
  endtask

  task automatic run_txn(input txn_t t);
    logic exp_err;
    int   lat;
    exp_t e;
    exp_err = t.rnw && !((t.addr == SLAVE_ADDR) && (t.busy <= TO - 1));
    if (!t.rnw)      lat = 4 + t.gnt_dly;
    else if (exp_err) lat = 3 + TO + t.gnt_dly;
    else             lat = 4 + t.gnt_dly + t.busy;
    if (t.rnw && !exp_err) last_rd = t.rdata;
    e.err  = exp_err;
    e.data = last_rd;
    wait_ready();
    en = 1'b1; rnw = t.rnw; address = t.addr; data_in = t.wdata;
    s_busy = t.busy; s_data = t.rdata; bus_gnt = 1'b0;
    sb_q.push_back(e);
    tick();
    en = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      bus_gnt = (k == t.gnt_dly + 1);
      if (k <= t.gnt_dly + 1) begin
        chk("arb_bus_req", 64'(bus_req), 64'd1);
        chk("arb_bus_z", 64'(bus_idle()), 64'd1);
        chk("arb_ready", 64'(ready), 64'd0);
      end
      if (k == t.gnt_dly + 2) begin
        chk("send_address", 64'(bus_address), 64'(t.addr));
        chk("send_data", 64'(bus_data), 64'(t.wdata));
        chk("send_control", 64'(bus_control), 64'({t.rnw, 1'b1}));
      end
      if (k < lat)  chk("done_early", 64'(done), 64'd0);
      if (k == lat) chk("done_at_latency", 64'(done), 64'd1);
      if (k == lat + 1) begin
        chk("post_done_ready", 64'(ready), 64'd0);
        chk("post_done_bus_req", 64'(bus_req), 64'd0);
      end
      if (k == lat + 2) chk("ready_rise", 64'(ready), 64'd1);
      tick();
    end
    bus_gnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rnw = 1'b0; address = '0; data_in = '0; bus_gnt = 1'b0;
    s_busy = 0; s_data = '0; last_rd = '0;

    vec[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 0};
    vec[1] = '{1'b1, 32'h0000_0010, 32'h0000_0001, 32'hCAFE_F00D, 0, 1};
    vec[2] = '{1'b0, 32'h0000_0044, 32'h1234_5678, 32'h0,         3, 0};
    vec[3] = '{1'b1, 32'h0000_0010, 32'h0000_0002, 32'hA5A5_5A5A, 2, 0};
    vec[4] = '{1'b1, 32'h0000_0020, 32'h0000_0003, 32'h9999_9999, 0, 0};
    vec[5] = '{1'b1, 32'h0000_0010, 32'h0000_0004, 32'h1111_2222, 0, 15};
    vec[6] = '{1'b1, 32'h0000_0010, 32'h0000_0005, 32'h3333_4444, 1, 16};
    vec[7] = '{1'b1, 32'h0000_0010, 32'h0000_0006, 32'h0F0F_0F0F, 1, 4};
    vec[8] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         0, 0};
    vec[9] = '{1'b0, 32'h0000_0100, 32'hAAAA_5555, 32'h0,         5, 0};

    tick(); tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_z", 64'(bus_idle()), 64'd1);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(ready), 64'd1);

    for (int i = 0; i < 10; i++) run_txn(vec[i]);

    // en held high: one transaction per IDLE visit, ignored while ready=0.
    wait_ready();
    en = 1'b1; rnw = 1'b0; address = 32'h0000_0080; data_in = 32'h0102_0304; bus_gnt = 1'b1;
    sb_q.push_back('{1'b0, last_rd});
    for (int k = 0; k <= 13; k++) begin
      if (k == 1)  chk("held_t1_ready", 64'(ready), 64'd0);
      if (k == 2)  chk("held_t2_address", 64'(bus_address), 64'h80);
      if (k == 4)  chk("held_t4_done", 64'(done), 64'd1);
      if (k == 5) begin
        chk("held_t5_ready", 64'(ready), 64'd0);
        chk("held_t5_bus_req", 64'(bus_req), 64'd0);
        address = 32'h0000_0084; data_in = 32'h0506_0708;
      end
      if (k == 6) begin
        chk("held_t6_ready", 64'(ready), 64'd1);
        sb_q.push_back('{1'b0, last_rd});
      end
      if (k == 7) chk("held_t7_bus_req", 64'(bus_req), 64'd1);
      if (k == 8) begin
        chk("held_t8_address", 64'(bus_address), 64'h84);
        chk("held_t8_data", 64'(bus_data), 64'h0506_0708);
      end
      if (k == 9)  chk("held_t9_done", 64'(done), 64'd0);
      if (k == 10) chk("held_t10_done", 64'(done), 64'd1);
      if (k == 11) begin
        chk("held_t11_ready", 64'(ready), 64'd0);
        en = 1'b0;
      end
      if (k == 13) chk("held_t13_bus_req", 64'(bus_req), 64'd0);
      tick();
    end

    // Reset during read WAIT_RSP abandons the transaction silently.
    wait_ready();
    en = 1'b1; rnw = 1'b1; address = 32'h0000_0020; data_in = 32'h0; bus_gnt = 1'b1;
    tick();
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k >= 3) chk("wait_bus_req", 64'(bus_req), 64'd1);
      if (k == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0; bus_gnt = 1'b0; last_rd = '0;
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_bus_req", 64'(bus_req), 64'd0);
    chk("midrst_bus_z", 64'(bus_idle()), 64'd1);
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_data_out", 64'(data_out), 64'd0);
    for (int k = 0; k < 20; k++) tick();
    run_txn('{1'b0, 32'h0000_0010, 32'h7654_3210, 32'h0, 0, 0});

    for (int k = 0; k < 4; k++) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_master.md
BIU_MASTER -- requirements
Module: biu_master

Interface
REQ-001 Parameter ADDR_WIDTH, 32, bus and user address width, SHALL be supported.
REQ-002 Parameter DATA_WIDTH, 32, bus and user data width, SHALL be supported.
REQ-003 Parameter TIMEOUT, 16, maximum read-response wait in cycles (>=2), SHALL be supported.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  user request strobe, accepted only when ready=1
- rnw  in  1  1=read, 0=write
- address  in  ADDR_WIDTH  user target address
- data_in  in  DATA_WIDTH  user write data
- ready  out  1  block idle, can accept en
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; 1 = read timed out
- data_out  out  DATA_WIDTH  read data, valid when done=1 and error=0
- bus_req  out  1  arbitration request
- bus_gnt  in  1  arbitration grant
- bus_address  inout  ADDR_WIDTH  shared bus address
- bus_data  inout  DATA_WIDTH  shared bus data
- bus_control  inout  2  [1]=rnw, [0]=data_valid

Function
REQ-005 The FSM SHALL have one-hot states IDLE, ARB, SEND_REQ, WAIT_RSP, DONE.
REQ-006 In IDLE, ready SHALL be 1; en=1 SHALL latch rnw/address/data_in and go to ARB; en while ready=0 SHALL be ignored.
REQ-007 bus_req SHALL be 1 in ARB, SEND_REQ and WAIT_RSP, and 0 in IDLE and DONE.
REQ-008 In ARB, the FSM SHALL go to SEND_REQ on the cycle bus_gnt=1 and SHALL otherwise wait indefinitely.
REQ-009 In SEND_REQ, the bus SHALL be driven for exactly one cycle with {latched address, latched data, rnw, 1'b1}, then the FSM SHALL go to WAIT_RSP.
REQ-010 In every state except SEND_REQ, all bus_* lines SHALL be high-impedance.
REQ-011 For a write, WAIT_RSP SHALL last exactly one cycle (the target's request-capture cycle), then the FSM SHALL go to DONE with error=0.
REQ-012 For a read, WAIT_RSP SHALL capture bus_data into data_out and go to DONE with error=0 on the first cycle bus_control==2'b11.
REQ-013 A timeout counter (width $clog2(TIMEOUT)+1) SHALL clear on entering WAIT_RSP and increment each read WAIT_RSP cycle without response; at count TIMEOUT-1 with no response, the FSM SHALL go to DONE with error=1 and data_out unchanged.
REQ-014 A response and the timeout in the same cycle SHALL resolve to the response (error=0).
REQ-015 bus_control==2'b10 (target busy, data_valid=0) or Z/X on bus_control SHALL NOT count as a response.
REQ-016 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE; ready SHALL rise the following cycle.
REQ-017 bus_gnt deasserting after ARB SHALL NOT abort the transaction.
REQ-018 data_out and error SHALL hold their values until the next DONE.

Reset
REQ-019 With rst=1 at a clock edge, the state SHALL be IDLE and bus_req, done and error SHALL be 0, data_out all 0s and the counter 0, bus_* SHALL be Z, and ready SHALL be 1 on the cycle after the reset edge.
REQ-020 Reset in any state, including mid-SEND_REQ or WAIT_RSP, SHALL abandon the transaction without a done pulse.

Verification
REQ-021 Write with bus_gnt=1 and en=1 at T0, address=0x10, data_in=0xDEADBEEF -> ARB at T1, bus driven {0x10,0xDEADBEEF,0,1} at T2, Z at T3, done=1/error=0 at T4, ready=1 at T6.
REQ-022 Read to a biu_slave at 0x10 returning 0xCAFEF00D immediately -> bus_control=2'b10 at T3, 2'b11 at T4, done=1/data_out=0xCAFEF00D at T5.
REQ-023 Read to an unmapped address with TIMEOUT=16 -> done=1, error=1 exactly 16 cycles after entering WAIT_RSP; data_out retains its previous value.
REQ-024 bus_gnt held 0 for 5 cycles after en -> bus stays Z, bus_req=1 throughout; SEND_REQ on the cycle after bus_gnt rises.
REQ-025 rst=1 during read WAIT_RSP -> no done, bus_req=0 and bus Z after the edge; a new write then completes normally.
REQ-026 en=1 held continuously -> exactly one transaction per IDLE visit, with no request accepted while ready=0.
